// File: rtl/bfly_router_radix.sv
// Radix-N butterfly routing switch with per-output round-robin arbitration
// and a fixed-latency response return path per input.
module bfly_router_radix #(
   parameter int unsigned Radix         = 4,
   parameter int unsigned AddWidth      = 8,
   parameter int unsigned ReqDataWidth  = 32,
   parameter int unsigned RespDataWidth = 32,
   parameter int unsigned RespLatency   = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [Radix-1:0]                      req_i,
   output logic [Radix-1:0]                      gnt_o,
   input  logic [Radix-1:0][AddWidth-1:0]        add_i,
   input  logic [Radix-1:0][ReqDataWidth-1:0]    data_i,
   output logic [Radix-1:0][RespDataWidth-1:0]   rdata_o,
   output logic [Radix-1:0]                      rvalid_o,
   output logic [Radix-1:0]                      req_o,
   input  logic [Radix-1:0]                      gnt_i,
   output logic [Radix-1:0][AddWidth-1:0]        add_o,
   output logic [Radix-1:0][ReqDataWidth-1:0]    data_o,
   input  logic [Radix-1:0][RespDataWidth-1:0]   rdata_i
);

   localparam int unsigned L = $clog2(Radix);

   logic [Radix-1:0][L-1:0]     dest;
   logic [Radix-1:0][Radix-1:0] cand;
   logic [Radix-1:0][L-1:0]     win;
   logic [Radix-1:0][L-1:0]     rr_q;

   logic [Radix-1:0][RespLatency-1:0]        v_q;
   logic [Radix-1:0][RespLatency-1:0][L-1:0] sel_q;

   // First set bit of c at or above start, wrapping; 0 when c is empty.
   function automatic logic [L-1:0] rr_pick(
      input logic [Radix-1:0] c,
      input logic [L-1:0]     start
   );
      logic [L-1:0] idx;
      logic         hit;
      rr_pick = '0;
      hit     = 1'b0;
      for (int k = 0; k < Radix; k++) begin
         idx = start + L'(k);
         if (!hit && c[idx]) begin
            hit     = 1'b1;
            rr_pick = idx;
         end
      end
   endfunction

   always_comb begin
      dest = '0;
      for (int i = 0; i < Radix; i++) begin
         dest[i] = add_i[i][AddWidth-1 -: L];
      end
   end

   always_comb begin
      cand = '0;
      for (int o = 0; o < Radix; o++) begin
         for (int i = 0; i < Radix; i++) begin
            cand[o][i] = req_i[i] && (dest[i] == L'(o));
         end
      end
   end

   for (genvar o = 0; o < Radix; o++) begin : g_out
      assign win[o]    = rr_pick(cand[o], rr_q[o]);
      assign req_o[o]  = |cand[o];
      assign add_o[o]  = add_i[win[o]] << L;
      assign data_o[o] = data_i[win[o]];
   end

   for (genvar i = 0; i < Radix; i++) begin : g_in
      assign gnt_o[i] = req_i[i] & gnt_i[dest[i]]
                      & (win[dest[i]] == L'(i));
      assign rvalid_o[i] = v_q[i][RespLatency-1];
      assign rdata_o[i]  = rdata_i[sel_q[i][RespLatency-1]];
   end

   // Pointer only moves on a handshake so a stalled winner stays put.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else begin
         for (int o = 0; o < Radix; o++) begin
            if (req_o[o] && gnt_i[o]) begin
               rr_q[o] <= win[o] + L'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q   <= '0;
         sel_q <= '0;
      end else begin
         for (int i = 0; i < Radix; i++) begin
            v_q[i][0] <= gnt_o[i];
            if (gnt_o[i]) begin
               sel_q[i][0] <= dest[i];
            end
            for (int s = 1; s < RespLatency; s++) begin
               v_q[i][s]   <= v_q[i][s-1];
               sel_q[i][s] <= sel_q[i][s-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_bfly_router_radix.sv
// Randomised and directed bench for bfly_router_radix against a
// cycle-level reference model of arbitration and response return.
module tb_bfly_router_radix;

   localparam int R   = 4;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int RW  = 32;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [R-1:0]          req, gnt_o, rvalid_o, req_o, gnt_i;
   logic [R-1:0][AW-1:0]  add, add_o;
   logic [R-1:0][DW-1:0]  data, data_o;
   logic [R-1:0][RW-1:0]  rdata_o, rdata_i;

   bfly_router_radix #(
      .Radix(R), .AddWidth(AW), .ReqDataWidth(DW),
      .RespDataWidth(RW), .RespLatency(LAT)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_i(req), .gnt_o(gnt_o),
      .add_i(add), .data_i(data),
      .rdata_o(rdata_o), .rvalid_o(rvalid_o),
      .req_o(req_o), .gnt_i(gnt_i),
      .add_o(add_o), .data_o(data_o),
      .rdata_i(rdata_i)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int rr [R];
   bit due_v [64][R];
   int due_sel [64][R];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic int dst(input int i);
      return int'(add[i][AW-1 -: 2]);
   endfunction

   task automatic clear_model();
      for (int o = 0; o < R; o++) rr[o] = 0;
      for (int s = 0; s < 64; s++)
         for (int i = 0; i < R; i++) due_v[s][i] = 1'b0;
   endtask

   task automatic rand_rdata();
      for (int i = 0; i < R; i++) rdata_i[i] = $urandom;
   endtask

   task automatic rand_all();
      for (int i = 0; i < R; i++) begin
         add[i]  = AW'($urandom);
         data[i] = $urandom;
      end
      rand_rdata();
      req   = R'($urandom);
      gnt_i = R'($urandom);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      clear_model();
   endtask

   // Called just after a rising edge with inputs already driven.
   task automatic step(input int want_gnt = -1, input int want_rv = -1);
      int win [R];
      bit hit [R];
      logic [R-1:0]  er, eg, erv;
      logic [AW-1:0] ea;
      int slot, i, d;
      #3;
      slot = cyc % 64;
      for (int o = 0; o < R; o++) begin
         hit[o] = 1'b0;
         win[o] = 0;
         for (int k = 0; k < R; k++) begin
            i = (rr[o] + k) % R;
            if (!hit[o] && req[i] && dst(i) == o) begin
               hit[o] = 1'b1;
               win[o] = i;
            end
         end
         er[o] = hit[o];
      end
      for (int j = 0; j < R; j++) begin
         d = dst(j);
         eg[j] = req[j] && gnt_i[d] && (win[d] == j);
         erv[j] = due_v[slot][j];
      end
      chk("req_o", req_o, er);
      chk("gnt_o", gnt_o, eg);
      if (want_gnt >= 0) chk("gnt_dir", gnt_o, want_gnt[R-1:0]);
      for (int o = 0; o < R; o++) begin
         ea = add[win[o]] << 2;
         chk("add_o", add_o[o], ea);
         chk("data_o", data_o[o], data[win[o]]);
      end
      chk("rvalid_o", rvalid_o, erv);
      if (want_rv >= 0) chk("rv_dir", rvalid_o, want_rv[R-1:0]);
      for (int j = 0; j < R; j++) begin
         if (erv[j])
            chk("rdata_o", rdata_o[j], rdata_i[due_sel[slot][j]]);
         else if (rst)
            chk("rdata_rst", rdata_o[j], rdata_i[0]);
         due_v[slot][j] = 1'b0;
      end
      @(posedge clk);
      if (rst) begin
         clear_model();
      end else begin
         for (int o = 0; o < R; o++)
            if (hit[o] && gnt_i[o]) rr[o] = (win[o] + 1) % R;
         for (int j = 0; j < R; j++) begin
            if (eg[j]) begin
               due_v[(cyc + LAT) % 64][j]   = 1'b1;
               due_sel[(cyc + LAT) % 64][j] = dst(j);
            end
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      clear_model();
      rand_all();
      #1;
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         rand_all();
         step(-1, 0);
      end
      rst = 1'b0;

      // conflict on output 0 from inputs 1 and 3
      rand_all();
      req    = 4'b1010;
      add[1] = 8'h11;
      add[3] = 8'h25;
      gnt_i  = 4'b1111;
      step(4'b0010);

      // full permutation
      rand_rdata();
      add[0] = 8'hC3;
      add[1] = 8'h8A;
      add[2] = 8'h4F;
      add[3] = 8'h21;
      req    = 4'b1111;
      step(4'b1111);

      // round robin on output 2
      pulse_rst();
      for (int i = 0; i < R; i++) add[i] = {2'b10, 6'($urandom)};
      req = 4'b1111;
      for (int n = 0; n < R; n++) begin
         rand_rdata();
         step(1 << n);
         req[n] = 1'b0;
      end
      req = 4'b1111;
      step(4'b0001);

      // backpressure on output 2
      req   = 4'b1110;
      gnt_i = 4'b1011;
      for (int n = 0; n < 3; n++) begin
         rand_rdata();
         step(0);
      end
      gnt_i = 4'b1111;
      step(4'b0010);
      req = '0;
      step(0);
      step(0);

      // response latency, back-to-back grants on input 1
      req    = 4'b0010;
      add[1] = 8'hC0;
      rand_rdata();
      step(4'b0010);
      add[1] = 8'h00;
      rand_rdata();
      step(4'b0010);
      req = '0;
      rand_rdata();
      step(-1, 4'b0010);
      rand_rdata();
      step(-1, 4'b0010);
      step(-1, 0);

      // reset while a response is in flight
      req    = 4'b0001;
      add[0] = 8'h40;
      step(4'b0001);
      req = '0;
      pulse_rst();
      for (int n = 0; n < 5; n++) begin
         rand_rdata();
         step(-1, 0);
      end

      for (int n = 0; n < 400; n++) begin
         rand_all();
         if ($urandom_range(0, 49) == 0) pulse_rst();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
